// File: rtl/hgcal_pkg.sv
// Shared definitions for the HGCAL autoencoder input path: activation width,
// default beat geometry, deserializer state encoding and an index-width helper.
package hgcal_pkg;

   localparam int ACT_W         = 2;
   localparam int BEAT_W_DEF    = 8;
   localparam int NUM_BEATS_DEF = 4;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HOLD = 2'd1,
      DROP = 2'd2
   } state_t;

   function automatic int idx_w(input int num_beats);
      return (num_beats <= 2) ? 1 : $clog2(num_beats);
   endfunction

endpackage

// File: rtl/hgcal_out_slice.sv
// Valid/ready output register: loads a new word whenever the slot is free,
// holding data stable while the consumer stalls.
module hgcal_out_slice #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   output logic         o_free,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   input  logic         i_ready
);

   logic [W-1:0] r_data;
   logic         r_valid;

   // A word being accepted this cycle frees the slot for a same-cycle replace.
   assign o_free  = !r_valid || i_ready;
   assign o_data  = r_data;
   assign o_valid = r_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/hgcal_act_deserializer.sv
// Assembles NUM_BEATS narrow activation beats into one layer0 input vector,
// double-buffered behind a valid/ready output slot; malformed frames are dropped.
module hgcal_act_deserializer
   import hgcal_pkg::*;
#(
   parameter  int BEAT_W    = BEAT_W_DEF,
   parameter  int NUM_BEATS = NUM_BEATS_DEF,
   parameter  int CNT_W     = 16,
   localparam int OUT_W     = BEAT_W * NUM_BEATS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BEAT_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [OUT_W-1:0]  m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              frame_err,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam int               IDX_W    = idx_w(NUM_BEATS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [OUT_W-1:0] r_buf;
   logic             r_pend;
   logic             w_pend_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             r_en;
   logic [CNT_W-1:0] r_cnt;
   logic             w_accept;
   logic             w_wr;
   logic             w_free;
   logic             w_load;

   assign s_ready   = r_en && (r_state != HOLD);
   assign w_accept  = s_valid && s_ready;
   assign frame_err = r_err;
   assign frame_cnt = r_cnt;

   // r_pend marks a completed buffer that was granted the free slot; it moves
   // out on the next edge while the following sample starts overwriting beat 0.
   assign w_load = r_pend || ((r_state == HOLD) && w_free);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FILL;
         r_idx   <= '0;
         r_pend  <= 1'b0;
         r_err   <= 1'b0;
         r_en    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_pend  <= w_pend_nxt;
         r_err   <= w_err_nxt;
         r_en    <= 1'b1;
         if (m_valid && m_ready) r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_err_nxt   = 1'b0;
      w_pend_nxt  = 1'b0;
      w_wr        = 1'b0;
      case (r_state)
         FILL: begin
            if (w_accept) begin
               w_wr = 1'b1;
               if (r_idx == LAST_IDX) begin
                  w_idx_nxt = '0;
                  if (!s_last) begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = DROP;
                  end else if (w_free) begin
                     w_pend_nxt = 1'b1;
                  end else begin
                     w_state_nxt = HOLD;
                  end
               end else if (s_last) begin
                  w_err_nxt = 1'b1;
                  w_idx_nxt = '0;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
         HOLD: begin
            if (w_free) w_state_nxt = FILL;
         end
         DROP: begin
            if (w_accept && s_last) begin
               w_state_nxt = FILL;
               w_idx_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = FILL;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf <= '0;
      end else if (w_wr) begin
         r_buf[int'(r_idx)*BEAT_W +: BEAT_W] <= s_data;
      end
   end

   hgcal_out_slice #(
      .W (OUT_W)
   ) u_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_data  (r_buf),
      .o_free  (w_free),
      .o_data  (m_data),
      .o_valid (m_valid),
      .i_ready (m_ready)
   );

endmodule

// File: tb/tb_hgcal_act_deserializer.sv
// Scoreboard bench for hgcal_act_deserializer: a frame-level reference model
// predicts delivered vectors and framing errors; a monitor checks the output side.
module tb_hgcal_act_deserializer;

   localparam int BW = 8;
   localparam int NB = 4;
   localparam int CW = 16;
   localparam int OW = BW * NB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [BW-1:0] s_data;
   logic          s_valid;
   logic          s_last;
   logic          s_ready;
   logic [OW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          frame_err;
   logic [CW-1:0] frame_cnt;

   hgcal_act_deserializer #(
      .BEAT_W    (BW),
      .NUM_BEATS (NB),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .frame_err (frame_err),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [OW-1:0] sb[$];
   int            hs_cyc[$];
   logic [BW-1:0] cur[$];
   bit            dropping = 0;
   bit            rand_mr = 0;
   int            err_exp = 0;
   int            err_seen = 0;
   int            pushed = 0;
   int            dlv_cnt = 0;
   int            stalls = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Frame-level model: a good frame is exactly NB beats with last on the final one.
   task automatic model_beat(input logic [BW-1:0] d, input logic l);
      logic [OW-1:0] v;
      if (dropping) begin
         if (l) dropping = 0;
      end else begin
         cur.push_back(d);
         if (l) begin
            if (cur.size() == NB) begin
               v = '0;
               for (int k = 0; k < NB; k++) v[k*BW +: BW] = cur[k];
               sb.push_back(v);
               pushed++;
            end else begin
               err_exp++;
            end
            cur.delete();
         end else if (cur.size() == NB) begin
            err_exp++;
            cur.delete();
            dropping = 1;
         end
      end
   endtask

   task automatic model_reset();
      cur.delete();
      sb.delete();
      dropping = 0;
      pushed   = 0;
      dlv_cnt  = 0;
   endtask

   task automatic drive_mr();
      if (rand_mr) m_ready = ($urandom_range(0, 9) < 7);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         drive_mr();
         s_valid = 1'b0;
         s_data  = BW'($urandom);
         s_last  = 1'($urandom);
      end
   endtask

   task automatic send_beat(input logic [BW-1:0] d, input logic l);
      int w;
      w = 0;
      @(negedge clk);
      drive_mr();
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!s_ready && w < 1000) begin
         @(negedge clk);
         drive_mr();
         w++;
         stalls++;
      end
      if (w >= 1000) begin
         checks++;
         errors++;
         $display("FAIL s_ready_timeout: got 0 expected 1 within 1000 cycles");
      end else begin
         model_beat(d, l);
      end
      @(posedge clk);
   endtask

   task automatic send_frame(input logic [OW-1:0] v);
      for (int k = 0; k < NB; k++) send_beat(v[k*BW +: BW], (k == NB - 1));
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 3000) begin
         idle(1);
         w++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      idle(3);
   endtask

   // Output monitor: compares every handshake against the scoreboard.
   initial begin : monitor
      logic          prev_stall;
      logic [OW-1:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            prev_stall = 1'b0;
            continue;
         end
         chk("frame_cnt_track", 64'(frame_cnt), 64'(dlv_cnt[CW-1:0]));
         if (frame_err) err_seen++;
         if (prev_stall) begin
            chk("stall_valid", 64'(m_valid), 64'd1);
            chk("stall_data", 64'(m_data), 64'(prev_data));
         end
         if (m_valid && m_ready) begin
            dlv_cnt++;
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %0h expected none", m_data);
            end else begin
               chk("m_data", 64'(m_data), 64'(sb.pop_front()));
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int base;
      int n;
      int kind;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("s_ready_after_rst", 64'(s_ready), 64'd1);

      // Basic frame and latency
      m_ready = 1'b1;
      send_frame(32'h44332211);
      idle(1);
      chk("latency_early", 64'(m_valid), 64'd0);
      idle(1);
      chk("latency_valid", 64'(m_valid), 64'd1);
      chk("latency_data", 64'(m_data), 64'h44332211);
      idle(2);
      chk("cnt_after_first", 64'(frame_cnt), 64'd1);

      // Back-to-back throughput
      base   = hs_cyc.size();
      stalls = 0;
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < NB; k++) send_beat(BW'($urandom), (k == NB - 1));
      idle(3);
      chk("b2b_stalls", 64'(stalls), 64'd0);
      chk("b2b_count", 64'(hs_cyc.size() - base), 64'd3);
      if (hs_cyc.size() >= base + 3) begin
         chk("b2b_spacing0", 64'(hs_cyc[base+1] - hs_cyc[base]), 64'd4);
         chk("b2b_spacing1", 64'(hs_cyc[base+2] - hs_cyc[base+1]), 64'd4);
      end
      chk("cnt_after_b2b", 64'(frame_cnt), 64'd4);

      // Backpressure into HOLD
      m_ready = 1'b0;
      send_frame(32'h04030201);
      send_frame(32'h08070605);
      idle(2);
      chk("hold_s_ready", 64'(s_ready), 64'd0);
      chk("hold_m_valid", 64'(m_valid), 64'd1);
      chk("hold_m_data", 64'(m_data), 64'h04030201);
      @(negedge clk);
      m_ready = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      m_ready = 1'b0;
      chk("release_m_valid", 64'(m_valid), 64'd1);
      chk("release_m_data", 64'(m_data), 64'h08070605);
      chk("release_s_ready", 64'(s_ready), 64'd1);
      m_ready = 1'b1;
      idle(3);

      // Early last
      send_beat(8'h55, 1'b0);
      send_beat(8'h66, 1'b1);
      send_frame(32'hD4C3B2A1);
      drain();
      chk("early_err", 64'(err_seen), 64'(err_exp));
      chk("early_data", 64'(m_data), 64'hD4C3B2A1);
      chk("early_cnt", 64'(frame_cnt), 64'(pushed));

      // Late last
      for (int k = 0; k < 6; k++) send_beat(BW'(8'h70 + k), (k == 5));
      send_frame(32'hE4E3E2E1);
      drain();
      chk("late_err", 64'(err_seen), 64'(err_exp));
      chk("late_data", 64'(m_data), 64'hE4E3E2E1);
      chk("late_cnt", 64'(frame_cnt), 64'(pushed));

      // Reset mid-frame
      send_beat(8'h01, 1'b0);
      send_beat(8'h02, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      s_valid = 1'b0;
      model_reset();
      #1;
      chk("midrst_m_valid", 64'(m_valid), 64'd0);
      chk("midrst_cnt", 64'(frame_cnt), 64'd0);
      idle(2);
      chk("midrst_frame_err", 64'(frame_err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(32'h0C0B0A09);
      drain();
      chk("midrst_err", 64'(err_seen), 64'(err_exp));
      chk("midrst_post_cnt", 64'(frame_cnt), 64'd1);

      // Randomized traffic with random backpressure and gaps
      rand_mr = 1;
      for (int f = 0; f < 150; f++) begin
         kind = $urandom_range(0, 99);
         if (kind < 85)      n = NB;
         else if (kind < 92) n = $urandom_range(1, NB - 1);
         else                n = $urandom_range(NB + 1, NB + 3);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_beat(BW'($urandom), (k == n - 1));
         end
      end
      drain();
      rand_mr = 0;
      m_ready = 1'b1;
      idle(2);
      chk("rand_err", 64'(err_seen), 64'(err_exp));
      chk("rand_cnt", 64'(frame_cnt), 64'(pushed));
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
